// File: rtl/mu0_control.sv
// MU0 processor control unit: two-cycle fetch/execute sequencer plus a halt state.
// Datapath selects, load enables and memory strobes are decoded combinationally from state and opcode.
module mu0_control (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  output logic       X_sel,
  output logic       Y_sel,
  output logic       Addr_sel,
  output logic [1:0] ALU_fs,
  output logic       PC_En,
  output logic       IR_En,
  output logic       Acc_En,
  output logic       Rd,
  output logic       Wr,
  output logic       Fetch,
  output logic       Halted
);

  // state   | meaning
  // FETCH   | read instruction at PC into IR, PC <= PC+1
  // EXECUTE | carry out the opcode held in IR
  // HALT    | stopped by STP, leaves only on Reset
  typedef enum logic [1:0] {
    S_FETCH   = 2'b00,
    S_EXECUTE = 2'b01,
    S_HALT    = 2'b10
  } state_t;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  localparam logic [1:0] ALU_B   = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_INC = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  state_t r_state;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:   r_state <= S_EXECUTE;
        S_EXECUTE: r_state <= (F == OP_STP) ? S_HALT : S_FETCH;
        S_HALT:    r_state <= S_HALT;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    Addr_sel = 1'b0;
    ALU_fs   = ALU_B;
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    Acc_En   = 1'b0;
    Rd       = 1'b0;
    Wr       = 1'b0;
    Fetch    = 1'b0;
    Halted   = 1'b0;
    case (r_state)
      S_FETCH: begin
        Fetch  = 1'b1;
        Rd     = 1'b1;
        IR_En  = 1'b1;
        X_sel  = 1'b1;
        ALU_fs = ALU_INC;
        PC_En  = 1'b1;
      end
      S_EXECUTE: begin
        case (F)
          OP_LDA: begin
            Addr_sel = 1'b1;
            Rd       = 1'b1;
            ALU_fs   = ALU_B;
            Acc_En   = 1'b1;
          end
          OP_STA: begin
            Addr_sel = 1'b1;
            Wr       = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            Addr_sel = 1'b1;
            Rd       = 1'b1;
            ALU_fs   = (F == OP_ADD) ? ALU_ADD : ALU_SUB;
            Acc_En   = 1'b1;
          end
          // Jump target is IR[11:0] passed straight through the ALU.
          OP_JMP, OP_JGE, OP_JNE: begin
            Y_sel  = 1'b1;
            ALU_fs = ALU_B;
            case (F)
              OP_JGE:  PC_En = ~N;
              OP_JNE:  PC_En = ~Z;
              default: PC_En = 1'b1;
            endcase
          end
          default: ;
        endcase
      end
      S_HALT: Halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mu0_control.sv
// Directed bench for mu0_control: checks the full output vector per state/opcode
// against hand-derived constants, including async reset behaviour and halt.
module tb_mu0_control;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] F;
  logic       N, Z;
  logic       X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, Rd, Wr, Fetch, Halted;
  logic [1:0] ALU_fs;

  int n_cmp = 0;
  int n_err = 0;

  mu0_control dut (
    .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z),
    .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel), .ALU_fs(ALU_fs),
    .PC_En(PC_En), .IR_En(IR_En), .Acc_En(Acc_En), .Rd(Rd), .Wr(Wr),
    .Fetch(Fetch), .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  // {Fetch,Halted,X_sel,Y_sel,Addr_sel,ALU_fs,PC_En,IR_En,Acc_En,Rd,Wr}
  logic [11:0] outs;
  assign outs = {Fetch, Halted, X_sel, Y_sel, Addr_sel, ALU_fs, PC_En, IR_En, Acc_En, Rd, Wr};

  localparam logic [11:0] E_FETCH = 12'b1_0_1_0_0_10_1_1_0_1_0;
  localparam logic [11:0] E_LDA   = 12'b0_0_0_0_1_00_0_0_1_1_0;
  localparam logic [11:0] E_STA   = 12'b0_0_0_0_1_00_0_0_0_0_1;
  localparam logic [11:0] E_ADD   = 12'b0_0_0_0_1_01_0_0_1_1_0;
  localparam logic [11:0] E_SUB   = 12'b0_0_0_0_1_11_0_0_1_1_0;
  localparam logic [11:0] E_JMP   = 12'b0_0_0_1_0_00_1_0_0_0_0;
  localparam logic [11:0] E_NOJ   = 12'b0_0_0_1_0_00_0_0_0_0_0;
  localparam logic [11:0] E_IDLE  = 12'b0_0_0_0_0_00_0_0_0_0_0;
  localparam logic [11:0] E_HALT  = 12'b0_1_0_0_0_00_0_0_0_0_0;

  // Advance one rising edge and settle 2 time units past it.
  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic test_reset();
    Reset = 1'b1; F = 4'd0; N = 1'b0; Z = 1'b0;
    #3;
    n_cmp++; if (outs !== E_FETCH) begin n_err++; $display("FAIL reset_async outs=%b exp=%b", outs, E_FETCH); end
    tick(); tick();
    n_cmp++; if (outs !== E_FETCH) begin n_err++; $display("FAIL reset_held outs=%b exp=%b", outs, E_FETCH); end
    Reset = 1'b0;
    #1;
    n_cmp++; if (outs !== E_FETCH) begin n_err++; $display("FAIL release_cyc1 outs=%b exp=%b", outs, E_FETCH); end
    tick();
    n_cmp++; if (outs !== E_LDA) begin n_err++; $display("FAIL release_cyc2_lda outs=%b exp=%b", outs, E_LDA); end
    tick();
    n_cmp++; if (outs !== E_FETCH) begin n_err++; $display("FAIL release_cyc3 outs=%b exp=%b", outs, E_FETCH); end
  endtask

  task automatic test_sta();
    F = 4'd1;
    tick();
    n_cmp++; if (outs !== E_STA) begin n_err++; $display("FAIL sta outs=%b exp=%b", outs, E_STA); end
    tick();
    n_cmp++; if (outs !== E_FETCH) begin n_err++; $display("FAIL sta_next outs=%b exp=%b", outs, E_FETCH); end
  endtask

  task automatic test_arith();
    F = 4'd2;
    tick();
    n_cmp++; if (outs !== E_ADD) begin n_err++; $display("FAIL add outs=%b exp=%b", outs, E_ADD); end
    tick();
    F = 4'd3;
    tick();
    n_cmp++; if (outs !== E_SUB) begin n_err++; $display("FAIL sub outs=%b exp=%b", outs, E_SUB); end
    tick();
    n_cmp++; if (outs !== E_FETCH) begin n_err++; $display("FAIL sub_next outs=%b exp=%b", outs, E_FETCH); end
  endtask

  task automatic test_jumps();
    F = 4'd4; N = 1'b1; Z = 1'b1;
    tick();
    n_cmp++; if (outs !== E_JMP) begin n_err++; $display("FAIL jmp outs=%b exp=%b", outs, E_JMP); end
    tick();
    F = 4'd5;
    tick();
    N = 1'b1; #1;
    n_cmp++; if (outs !== E_NOJ) begin n_err++; $display("FAIL jge_n1 outs=%b exp=%b", outs, E_NOJ); end
    N = 1'b0; #1;
    n_cmp++; if (outs !== E_JMP) begin n_err++; $display("FAIL jge_n0 outs=%b exp=%b", outs, E_JMP); end
    tick();
    F = 4'd6; N = 1'b0;
    tick();
    Z = 1'b1; #1;
    n_cmp++; if (outs !== E_NOJ) begin n_err++; $display("FAIL jne_z1 outs=%b exp=%b", outs, E_NOJ); end
    Z = 1'b0; #1;
    n_cmp++; if (outs !== E_JMP) begin n_err++; $display("FAIL jne_z0 outs=%b exp=%b", outs, E_JMP); end
    tick();
    n_cmp++; if (outs !== E_FETCH) begin n_err++; $display("FAIL jne_next outs=%b exp=%b", outs, E_FETCH); end
  endtask

  task automatic test_noop_sweep();
    for (int f = 8; f < 16; f++) begin
      F = 4'(f);
      tick();
      n_cmp++; if (outs !== E_IDLE) begin n_err++; $display("FAIL noop_f%0d outs=%b exp=%b", f, outs, E_IDLE); end
      tick();
      n_cmp++; if (outs !== E_FETCH) begin n_err++; $display("FAIL noop_next_f%0d outs=%b exp=%b", f, outs, E_FETCH); end
    end
  endtask

  task automatic test_reset_mid_exec();
    F = 4'd3;
    tick();
    n_cmp++; if (outs !== E_SUB) begin n_err++; $display("FAIL midexec_sub outs=%b exp=%b", outs, E_SUB); end
    #1 Reset = 1'b1;
    #1;
    n_cmp++; if (outs !== E_FETCH) begin n_err++; $display("FAIL midexec_abort outs=%b exp=%b", outs, E_FETCH); end
    #2 Reset = 1'b0;
    tick();
    n_cmp++; if (outs !== E_SUB) begin n_err++; $display("FAIL midexec_refetch outs=%b exp=%b", outs, E_SUB); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [4] = '{4'd0, 4'd2, 4'd1, 4'd6};
    logic [11:0] exps[4] = '{E_LDA, E_ADD, E_STA, E_JMP};
    Z = 1'b0;
    for (int i = 0; i < 4; i++) begin
      F = ops[i];
      n_cmp++; if (outs !== E_FETCH) begin n_err++; $display("FAIL b2b_fetch%0d outs=%b exp=%b", i, outs, E_FETCH); end
      tick();
      n_cmp++; if (outs !== exps[i]) begin n_err++; $display("FAIL b2b_exec%0d outs=%b exp=%b", i, outs, exps[i]); end
      tick();
    end
  endtask

  task automatic test_halt();
    F = 4'd7;
    tick();
    n_cmp++; if (outs !== E_IDLE) begin n_err++; $display("FAIL stp_exec outs=%b exp=%b", outs, E_IDLE); end
    tick();
    n_cmp++; if (outs !== E_HALT) begin n_err++; $display("FAIL halt_entry outs=%b exp=%b", outs, E_HALT); end
    for (int i = 0; i < 10; i++) begin
      F = 4'(i * 3 + 1);
      tick();
      n_cmp++; if (outs !== E_HALT) begin n_err++; $display("FAIL halt_hold%0d outs=%b exp=%b", i, outs, E_HALT); end
    end
    #1 Reset = 1'b1;
    #1;
    n_cmp++; if (outs !== E_FETCH) begin n_err++; $display("FAIL halt_reset outs=%b exp=%b", outs, E_FETCH); end
    #1 Reset = 1'b0;
    F = 4'd0;
    tick();
    n_cmp++; if (outs !== E_LDA) begin n_err++; $display("FAIL halt_restart outs=%b exp=%b", outs, E_LDA); end
    tick();
  endtask

  initial begin
    test_reset();
    test_sta();
    test_arith();
    test_jumps();
    test_noop_sweep();
    test_reset_mid_exec();
    test_back_to_back();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mu0_control.md
MU0_CONTROL -- requirements
Module: mu0_control

Interface
Parameters: none.
REQ-001 Clk  in  1  system clock; all state changes on rising edge.
REQ-002 Reset  in  1  asynchronous, active-high reset.
REQ-003 F  in  4  opcode field IR[15:12], taken from the IR register output.
REQ-004 N  in  1  accumulator negative flag, Acc[15].
REQ-005 Z  in  1  accumulator zero flag, Acc==16'h0000.
REQ-006 X_sel  out  1  ALU A-operand select: 0=Acc, 1=PC.
REQ-007 Y_sel  out  1  ALU B-operand select: 0=memory read data, 1=IR[11:0] zero-extended.
REQ-008 Addr_sel  out  1  memory address select: 0=PC, 1=IR[11:0].
REQ-009 ALU_fs  out  2  ALU function: 00=B, 01=A+B, 10=A+1, 11=A-B.
REQ-010 PC_En, IR_En, Acc_En  out  1 each  load enables for the PC, IR and Acc 16-bit registers.
REQ-011 Rd, Wr  out  1 each  memory read and write strobes.
REQ-012 Fetch  out  1  high while in FETCH state.
REQ-013 Halted  out  1  high while in HALT state.

Function
REQ-014 The block SHALL be a 3-state FSM with states FETCH, EXECUTE and HALT, and a 2-bit state register.
REQ-015 All outputs SHALL be combinational from state and F, with no output registers; any output not listed for a state SHALL be 0.
REQ-016 FETCH SHALL drive: Addr_sel=0, Rd=1, IR_En=1, X_sel=1, ALU_fs=10, PC_En=1; next state EXECUTE.
REQ-017 EXECUTE SHALL decode F as follows; next state FETCH unless stated:
- F=0 LDA: Addr_sel=1, Rd=1, Y_sel=0, ALU_fs=00, Acc_En=1.
- F=1 STA: Addr_sel=1, Wr=1, X_sel=0.
- F=2 ADD: Addr_sel=1, Rd=1, X_sel=0, Y_sel=0, ALU_fs=01, Acc_En=1.
- F=3 SUB: as ADD but ALU_fs=11.
- F=4 JMP: Y_sel=1, ALU_fs=00, PC_En=1.
- F=5 JGE: Y_sel=1, ALU_fs=00, PC_En=~N.
- F=6 JNE: Y_sel=1, ALU_fs=00, PC_En=~Z.
- F=7 STP: no enables or strobes; next state HALT.
- F=8..F: no-op; all enables and strobes 0.
REQ-018 HALT SHALL assert Halted=1 with all enables and strobes 0, and SHALL remain in HALT until Reset.
REQ-019 Rd and Wr SHALL never be 1 in the same cycle.
REQ-020 At most one of PC_En and Acc_En SHALL be 1 in EXECUTE.
REQ-021 Every instruction except STP SHALL take exactly 2 cycles (FETCH, then EXECUTE).
REQ-022 A conditional jump not taken SHALL leave PC at the value it was incremented to in FETCH.
REQ-023 Unknown or illegal state encodings SHALL transition to FETCH on the next edge.

Reset
REQ-024 Reset=1 SHALL force state to FETCH immediately, independent of Clk.
REQ-025 While Reset=1, outputs SHALL show the FETCH decode with Fetch=1 and Halted=0; the datapath registers are held in reset at the same time.
REQ-026 Reset asserted mid-EXECUTE SHALL abandon the instruction, and no further enable SHALL be driven from that decode.
REQ-027 Reset asserted in HALT SHALL return the block to FETCH.
REQ-028 On the first rising edge after Reset falls, the block SHALL perform the FETCH actions.

Verification
REQ-029 Reset release, F=0 -> cycle 1: Fetch=1, IR_En=PC_En=Rd=1, ALU_fs=10; cycle 2: Acc_En=1, Addr_sel=1, ALU_fs=00; cycle 3: Fetch=1.
REQ-030 EXECUTE with F=1 -> Wr=1, Rd=0, Addr_sel=1, X_sel=0, Acc_En=0, PC_En=0.
REQ-031 EXECUTE with F=5: N=1 -> PC_En=0; N=0 -> PC_En=1, Y_sel=1. EXECUTE with F=6: Z=1 -> PC_En=0; Z=0 -> PC_En=1.
REQ-032 EXECUTE with F=7 -> next edge Halted=1; 10 further clocks with any F -> Halted stays 1 and all enables 0; Reset pulse -> Fetch=1 and Halted=0 immediately.
REQ-033 EXECUTE with F=3 and Reset pulsed between clock edges -> Acc_En drops to 0 and Fetch=1 asynchronously.
REQ-034 Sweep F=8..F in EXECUTE -> all enables and strobes 0, and the next state is FETCH.
